// File: rtl/pkt_loopback_n_if.sv
// Packet bus bundle for the loopback reflector: one strobe plus packed
// source/target/data fields per port (port i at [i*W +: W]).
//   master : drives valid/source/target/data
//   slave  : receives valid/source/target/data
interface pkt_loopback_n_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SRC_W     = 2,
  parameter int unsigned TGT_W     = 4
);
  logic [NUM_PORTS-1:0]        valid;
  logic [NUM_PORTS*SRC_W-1:0]  source;
  logic [NUM_PORTS*TGT_W-1:0]  target;
  logic [NUM_PORTS*DATA_W-1:0] data;

  modport master (output valid, source, target, data);
  modport slave  (input  valid, source, target, data);
endinterface

// File: rtl/pkt_loopback_n.sv
// Loopback/reflector for the switch port protocol. Packets arriving on
// in_bus are queued in per-output FIFOs and re-emitted on out_bus, either on
// the same port (route_en=0) or on the lowest port named in the one-hot
// target (route_en=1). Each output paces itself with GAP idle cycles.
//   clk, rst     : single clock, synchronous active-high reset
//   route_en     : 0 = self loopback, 1 = route by target
//   in_bus       : incoming packets (slave)
//   out_bus      : emitted packets, fields zero when not valid (master)
//   drop_cnt     : saturating per-input-port dropped-packet counters
//   fifo_empty   : per-output FIFO empty flags
module pkt_loopback_n #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SRC_W     = 2,
  parameter int unsigned TGT_W     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GAP       = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       route_en,
  pkt_loopback_n_if.slave            in_bus,
  pkt_loopback_n_if.master           out_bus,
  output logic [NUM_PORTS*CNT_W-1:0] drop_cnt,
  output logic [NUM_PORTS-1:0]       fifo_empty
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
  localparam int unsigned GAP_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam bit          HAS_GAP = (GAP != 0);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [TGT_W-1:0]  tgt;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic {S_IDLE, S_GAP_WAIT} state_e;

  pkt_t                 in_pkt     [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_has_dst;
  logic [IDX_W-1:0]     in_dst     [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_en, drop, pop, accept;
  pkt_t                 wr_pkt     [NUM_PORTS];

  pkt_t             mem_q     [NUM_PORTS][DEPTH];
  pkt_t             mem_d     [NUM_PORTS][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q  [NUM_PORTS];
  logic [PTR_W-1:0] rd_ptr_d  [NUM_PORTS];
  logic [PTR_W-1:0] wr_ptr_q  [NUM_PORTS];
  logic [PTR_W-1:0] wr_ptr_d  [NUM_PORTS];
  logic [OCC_W-1:0] occ_q     [NUM_PORTS];
  logic [OCC_W-1:0] occ_d     [NUM_PORTS];
  state_e           state_q   [NUM_PORTS];
  state_e           state_d   [NUM_PORTS];
  logic [GAP_W-1:0] gap_q     [NUM_PORTS];
  logic [GAP_W-1:0] gap_d     [NUM_PORTS];
  pkt_t             out_pkt_q [NUM_PORTS];
  pkt_t             out_pkt_d [NUM_PORTS];
  logic [CNT_W-1:0] drop_q    [NUM_PORTS];
  logic [CNT_W-1:0] drop_d    [NUM_PORTS];
  logic [NUM_PORTS-1:0] valid_out_q, valid_out_d;
  logic [NUM_PORTS-1:0] fifo_empty_q, fifo_empty_d;

  // valid_out_q is asserted exactly in the cycle a head packet leaves its FIFO
  assign pop = valid_out_q;

  // Unpack inputs and resolve each input's destination port
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      in_pkt[i].src  = in_bus.source[i*SRC_W +: SRC_W];
      in_pkt[i].tgt  = in_bus.target[i*TGT_W +: TGT_W];
      in_pkt[i].data = in_bus.data[i*DATA_W +: DATA_W];
      in_has_dst[i]  = 1'b0;
      in_dst[i]      = '0;
      if (!route_en) begin
        in_has_dst[i] = 1'b1;
        in_dst[i]     = IDX_W'(i);
      end else begin
        // descending scan so the lowest set bit is the last one to land
        for (int b = int'(TGT_W) - 1; b >= 0; b--) begin
          if (in_bus.target[i*TGT_W + b]) begin
            in_has_dst[i] = 1'b1;
            in_dst[i]     = IDX_W'(b);
          end
        end
      end
    end
  end

  // Per-output arbitration (lowest input wins) and drop detection
  always_comb begin
    wr_en = '0;
    drop  = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      wr_pkt[p] = '0;
      // a full FIFO still takes a packet when its head leaves this cycle
      accept[p] = (occ_q[p] != OCC_W'(DEPTH)) || pop[p];
    end
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (in_bus.valid[i]) begin
        if (!in_has_dst[i]) begin
          drop[i] = 1'b1;
        end else begin
          for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (in_dst[i] == IDX_W'(p)) begin
              if (wr_en[p] || !accept[p]) begin
                drop[i] = 1'b1;
              end else begin
                wr_en[p]  = 1'b1;
                wr_pkt[p] = in_pkt[i];
              end
            end
          end
        end
      end
    end
  end

  // FIFO bookkeeping, scheduler next state and look-ahead output registers
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      state_d[p]  = state_q[p];
      gap_d[p]    = gap_q[p];
      rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
      wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(wr_en[p]);
      occ_d[p]    = occ_q[p] + OCC_W'(wr_en[p]) - OCC_W'(pop[p]);
      if (wr_en[p]) mem_d[p][wr_ptr_q[p]] = wr_pkt[p];

      case (state_q[p])
        S_IDLE: begin
          if (pop[p] && HAS_GAP) begin
            state_d[p] = S_GAP_WAIT;
            gap_d[p]   = GAP_W'(GAP);
          end
        end
        S_GAP_WAIT: begin
          gap_d[p] = gap_q[p] - GAP_W'(1);
          if (gap_q[p] <= GAP_W'(1)) state_d[p] = S_IDLE;
        end
        default: state_d[p] = S_IDLE;
      endcase

      // next cycle's emission is known now, so the outputs can be flops
      valid_out_d[p]  = (state_d[p] == S_IDLE) && (occ_d[p] != '0);
      out_pkt_d[p]    = valid_out_d[p] ? mem_d[p][rd_ptr_d[p]] : '0;
      fifo_empty_d[p] = (occ_d[p] == '0);
      drop_d[p]       = (drop[p] && (drop_q[p] != '1)) ? drop_q[p] + CNT_W'(1) : drop_q[p];
    end
  end

  // Control and output state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_q  <= '0;
      fifo_empty_q <= '1;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        rd_ptr_q[p]  <= '0;
        wr_ptr_q[p]  <= '0;
        occ_q[p]     <= '0;
        state_q[p]   <= S_IDLE;
        gap_q[p]     <= '0;
        out_pkt_q[p] <= '0;
        drop_q[p]    <= '0;
      end
    end else begin
      valid_out_q  <= valid_out_d;
      fifo_empty_q <= fifo_empty_d;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        rd_ptr_q[p]  <= rd_ptr_d[p];
        wr_ptr_q[p]  <= wr_ptr_d[p];
        occ_q[p]     <= occ_d[p];
        state_q[p]   <= state_d[p];
        gap_q[p]     <= gap_d[p];
        out_pkt_q[p] <= out_pkt_d[p];
        drop_q[p]    <= drop_d[p];
      end
    end
  end

  // Packet storage; contents are don't-care while the occupancy is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_bus.valid = valid_out_q;
  assign fifo_empty    = fifo_empty_q;

  for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_out
    assign out_bus.source[p*SRC_W +: SRC_W]  = out_pkt_q[p].src;
    assign out_bus.target[p*TGT_W +: TGT_W]  = out_pkt_q[p].tgt;
    assign out_bus.data[p*DATA_W +: DATA_W]  = out_pkt_q[p].data;
    assign drop_cnt[p*CNT_W +: CNT_W]        = drop_q[p];
  end
endmodule
